// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mm_pkg
// Purpose  : Shared types, constants and round-robin pick helper for the
//            Montgomery multiplier arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package mm_pkg;

    localparam int BRAM_DW = 17;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        START   = 3'd2,
        BUSY    = 3'd3,
        RELEASE = 3'd4,
        ABORT   = 3'd5
    } arb_state_t;

    // Scans from farthest to nearest so the first set bit at/after ptr wins.
    // Bits above the real requester count are zero, so mod-8 wrap equals mod-N.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] idx;
        rr_pick = ptr;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            idx = ptr + IDX_W'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/mm_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mm_rr_arbiter_if
// Purpose  : Requester handshake, per-requester BRAM buses and shared core port.
// Revision : 1.0 - initial release
// ============================================================================
interface mm_rr_arbiter_if
    import mm_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int AW    = 5
);
    logic [N_REQ-1:0]         req_i;
    logic [N_REQ-1:0]         gnt_o;
    logic [N_REQ-1:0]         req_done_o;
    logic [N_REQ-1:0]         req_err_o;
    logic [N_REQ-1:0]         req_bram_en_o;
    logic [N_REQ-1:0]         req_bram_we_o;
    logic [N_REQ*AW-1:0]      req_bram_addr_o;
    logic [N_REQ*BRAM_DW-1:0] req_bram_din_o;
    logic [N_REQ*BRAM_DW-1:0] req_bram_dout_i;
    logic                     mm_start_o;
    logic                     mm_reset_o;
    logic                     mm_done_i;
    logic                     mm_bram_en_i;
    logic                     mm_bram_we_i;
    logic [AW-1:0]            mm_bram_addr_i;
    logic [BRAM_DW-1:0]       mm_bram_din_i;
    logic [BRAM_DW-1:0]       mm_bram_dout_o;

    modport master (
        input  req_i,
        output gnt_o, req_done_o, req_err_o,
        output req_bram_en_o, req_bram_we_o, req_bram_addr_o, req_bram_din_o,
        input  req_bram_dout_i,
        output mm_start_o, mm_reset_o,
        input  mm_done_i, mm_bram_en_i, mm_bram_we_i, mm_bram_addr_i, mm_bram_din_i,
        output mm_bram_dout_o
    );

    modport slave (
        output req_i,
        input  gnt_o, req_done_o, req_err_o,
        input  req_bram_en_o, req_bram_we_o, req_bram_addr_o, req_bram_din_o,
        output req_bram_dout_i,
        input  mm_start_o, mm_reset_o,
        output mm_done_i, mm_bram_en_i, mm_bram_we_i, mm_bram_addr_i, mm_bram_din_i,
        input  mm_bram_dout_o
    );

endinterface
`default_nettype wire

// File: rtl/mm_bram_mux.sv
`default_nettype none
// ============================================================================
// Module   : mm_bram_mux
// Purpose  : Combinational router of the core BRAM port to the granted requester.
// Revision : 1.0 - initial release
// ============================================================================
module mm_bram_mux
    import mm_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int AW    = 5
) (
    input  wire logic [N_REQ-1:0]         i_gnt,
    input  wire logic                     i_mm_en,
    input  wire logic                     i_mm_we,
    input  wire logic [AW-1:0]            i_mm_addr,
    input  wire logic [BRAM_DW-1:0]       i_mm_din,
    output logic      [BRAM_DW-1:0]       o_mm_dout,
    output logic      [N_REQ-1:0]         o_req_en,
    output logic      [N_REQ-1:0]         o_req_we,
    output logic      [N_REQ*AW-1:0]      o_req_addr,
    output logic      [N_REQ*BRAM_DW-1:0] o_req_din,
    input  wire logic [N_REQ*BRAM_DW-1:0] i_req_dout
);

    logic [BRAM_DW-1:0] w_dout_masked [N_REQ];
    logic [BRAM_DW-1:0] w_dout;

    // Non-granted ports are fully quiet: no strobes, zero address and data.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
        assign o_req_en[gi]                       = i_gnt[gi] & i_mm_en;
        assign o_req_we[gi]                       = i_gnt[gi] & i_mm_we;
        assign o_req_addr[gi*AW +: AW]            = i_gnt[gi] ? i_mm_addr : '0;
        assign o_req_din[gi*BRAM_DW +: BRAM_DW]   = i_gnt[gi] ? i_mm_din  : '0;
        assign w_dout_masked[gi] = i_gnt[gi] ? i_req_dout[gi*BRAM_DW +: BRAM_DW] : '0;
    end

    always_comb begin
        w_dout = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dout = w_dout | w_dout_masked[i];
        end
    end

    assign o_mm_dout = w_dout;

endmodule
`default_nettype wire

// File: rtl/mm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mm_rr_arbiter
// Purpose  : Round-robin sequencer sharing one Montgomery core among N_REQ
//            requesters, with start/done handshake and a hung-core watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mm_rr_arbiter
    import mm_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int s       = 8,
    parameter int TIMEOUT = 4096
) (
    input  wire logic       clock_i,
    input  wire logic       reset_i,
    mm_rr_arbiter_if.master bus
);

    localparam int                AW         = $clog2(4 * s);
    localparam int                WD_W       = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]   c_WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(N_REQ - 1);

    arb_state_t        r_state,      w_state_nxt;
    logic [N_REQ-1:0]  r_gnt,        w_gnt_nxt;
    logic [IDX_W-1:0]  r_gnt_idx,    w_gnt_idx_nxt;
    logic [IDX_W-1:0]  r_ptr,        w_ptr_nxt;
    logic [WD_W-1:0]   r_wd_cnt,     w_wd_cnt_nxt;
    logic              r_abort_ph,   w_abort_ph_nxt;
    logic              r_core_rst;
    logic [IDX_W-1:0]  w_pick;
    logic [IDX_W-1:0]  w_idx_inc;
    logic              w_start;
    logic              w_done;
    logic              w_err;

    assign w_pick    = rr_pick(MAX_REQ'(bus.req_i), r_ptr);
    assign w_idx_inc = (r_gnt_idx == c_LAST_IDX) ? '0 : r_gnt_idx + 1'b1;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_ptr      <= '0;
            r_wd_cnt   <= '0;
            r_abort_ph <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_idx  <= w_gnt_idx_nxt;
            r_ptr      <= w_ptr_nxt;
            r_wd_cnt   <= w_wd_cnt_nxt;
            r_abort_ph <= w_abort_ph_nxt;
        end
    end

    // Holds the core in reset until the first clock edge after reset_i rises.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) r_core_rst <= 1'b1;
        else          r_core_rst <= 1'b0;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_gnt_idx_nxt  = r_gnt_idx;
        w_ptr_nxt      = r_ptr;
        w_wd_cnt_nxt   = r_wd_cnt;
        w_abort_ph_nxt = r_abort_ph;
        w_start        = 1'b0;
        w_done         = 1'b0;
        w_err          = 1'b0;

        case (r_state)
            IDLE: begin
                if (|bus.req_i) begin
                    w_state_nxt   = GRANT;
                    w_gnt_idx_nxt = w_pick;
                    w_gnt_nxt     = N_REQ'(1) << w_pick;
                end
            end
            GRANT: w_state_nxt = START;
            START: begin
                w_start      = 1'b1;
                w_wd_cnt_nxt = '0;
                w_state_nxt  = BUSY;
            end
            BUSY: begin
                w_wd_cnt_nxt = r_wd_cnt + 1'b1;
                if (bus.mm_done_i) begin
                    w_state_nxt = RELEASE;
                end else if (r_wd_cnt == c_WD_LAST) begin
                    w_state_nxt    = ABORT;
                    w_abort_ph_nxt = 1'b0;
                end
            end
            RELEASE: begin
                w_done      = 1'b1;
                w_gnt_nxt   = '0;
                w_ptr_nxt   = w_idx_inc;
                w_state_nxt = IDLE;
            end
            ABORT: begin
                // Two-cycle core reset; the error completion rides on the second.
                if (!r_abort_ph) begin
                    w_abort_ph_nxt = 1'b1;
                end else begin
                    w_done         = 1'b1;
                    w_err          = 1'b1;
                    w_gnt_nxt      = '0;
                    w_ptr_nxt      = w_idx_inc;
                    w_abort_ph_nxt = 1'b0;
                    w_state_nxt    = IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.gnt_o      = r_gnt;
    assign bus.req_done_o = w_done ? r_gnt : '0;
    assign bus.req_err_o  = w_err  ? r_gnt : '0;
    assign bus.mm_start_o = w_start;
    assign bus.mm_reset_o = r_core_rst | (r_state == ABORT);

    mm_bram_mux #(
        .N_REQ (N_REQ),
        .AW    (AW)
    ) u_bram_mux (
        .i_gnt      (r_gnt),
        .i_mm_en    (bus.mm_bram_en_i),
        .i_mm_we    (bus.mm_bram_we_i),
        .i_mm_addr  (bus.mm_bram_addr_i),
        .i_mm_din   (bus.mm_bram_din_i),
        .o_mm_dout  (bus.mm_bram_dout_o),
        .o_req_en   (bus.req_bram_en_o),
        .o_req_we   (bus.req_bram_we_o),
        .o_req_addr (bus.req_bram_addr_o),
        .o_req_din  (bus.req_bram_din_o),
        .i_req_dout (bus.req_bram_dout_i)
    );

endmodule
`default_nettype wire

// File: tb/tb_mm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm_rr_arbiter
// Purpose  : Directed self-checking bench for mm_rr_arbiter with a core model
//            and per-requester BRAM models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mm_rr_arbiter;

    localparam int N_REQ = 4;
    localparam int S_SEC = 8;
    localparam int AW    = $clog2(4 * S_SEC);
    localparam int DW    = 17;

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    always #5 clock_i = ~clock_i;

    mm_rr_arbiter_if #(.N_REQ(N_REQ), .AW(AW)) bus ();
    mm_rr_arbiter_if #(.N_REQ(N_REQ), .AW(AW)) wd_bus ();

    mm_rr_arbiter #(.N_REQ(N_REQ), .s(S_SEC), .TIMEOUT(4096)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    mm_rr_arbiter #(.N_REQ(N_REQ), .s(S_SEC), .TIMEOUT(64)) dut_wd (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (wd_bus)
    );

    // Watchdog instance sees a core that never answers.
    assign wd_bus.mm_done_i       = 1'b0;
    assign wd_bus.mm_bram_en_i    = 1'b0;
    assign wd_bus.mm_bram_we_i    = 1'b0;
    assign wd_bus.mm_bram_addr_i  = '0;
    assign wd_bus.mm_bram_din_i   = '0;
    assign wd_bus.req_bram_dout_i = '0;

    // Core model: after start, reads sequential addresses, optionally writes once
    // at count 2, and pulses done core_lat cycles later.
    int            core_lat     = 20;
    bit            core_wr      = 1'b0;
    logic [AW-1:0] core_wr_addr = AW'(5);
    logic [DW-1:0] core_wr_data = 17'h1ABCD;
    bit            spur_done    = 1'b0;
    bit            core_busy    = 1'b0;
    int            core_cnt     = 0;
    logic          core_done    = 1'b0;
    logic          core_en      = 1'b0;
    logic          core_we      = 1'b0;
    logic [AW-1:0] core_addr    = '0;
    logic [DW-1:0] core_din     = '0;

    always @(posedge clock_i) begin
        if (bus.mm_reset_o) begin
            core_busy <= 1'b0; core_cnt <= 0; core_done <= 1'b0;
            core_en   <= 1'b0; core_we  <= 1'b0;
        end else if (bus.mm_start_o) begin
            core_busy <= 1'b1; core_cnt <= 0; core_done <= 1'b0;
            core_en   <= 1'b0; core_we  <= 1'b0;
        end else if (core_busy) begin
            core_cnt  <= core_cnt + 1;
            core_en   <= 1'b1;
            core_we   <= core_wr && (core_cnt == 2);
            core_addr <= (core_cnt == 2) ? core_wr_addr : AW'(core_cnt);
            core_din  <= core_wr_data;
            if (core_cnt == core_lat - 1) begin
                core_done <= 1'b1;
                core_busy <= 1'b0;
            end
        end else begin
            core_done <= 1'b0; core_en <= 1'b0; core_we <= 1'b0;
        end
    end

    assign bus.mm_done_i      = core_done | spur_done;
    assign bus.mm_bram_en_i   = core_en;
    assign bus.mm_bram_we_i   = core_we;
    assign bus.mm_bram_addr_i = core_addr;
    assign bus.mm_bram_din_i  = core_din;

    logic [DW-1:0]       ram [N_REQ][32] = '{default: '0};
    logic [N_REQ*DW-1:0] ram_dout        = '0;

    always @(posedge clock_i) begin
        for (int p = 0; p < N_REQ; p++) begin
            if (bus.req_bram_en_o[p]) begin
                if (bus.req_bram_we_o[p])
                    ram[p][bus.req_bram_addr_o[p*AW +: AW]] <= bus.req_bram_din_o[p*DW +: DW];
                ram_dout[p*DW +: DW] <= ram[p][bus.req_bram_addr_o[p*AW +: AW]];
            end
        end
    end
    assign bus.req_bram_dout_i = ram_dout;

    int               n_checks = 0;
    int               n_errors = 0;
    int               cyc      = 0;
    logic [N_REQ-1:0] en_seen  = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
        cyc++;
        en_seen = en_seen | bus.req_bram_en_o;
    endtask

    task automatic wait_gnt(input string tag, input int limit);
        int n = 0;
        while (bus.gnt_o == '0 && n < limit) begin
            tick();
            n++;
        end
        check_eq({tag, "_gnt_timeout"}, 32'(n >= limit), 32'd0);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (bus.req_done_o == '0 && n < limit) begin
            tick();
            n++;
        end
        check_eq({tag, "_done_timeout"}, 32'(n >= limit), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got time %0t expected finish before it", $time);
        $fatal(1);
    end

    initial begin
        int last_done;
        int n;
        bus.req_i    = '0;
        wd_bus.req_i = '0;

        // Reset state
        repeat (3) @(posedge clock_i);
        #1;
        check_eq("rst_gnt",    bus.gnt_o,         0);
        check_eq("rst_done",   bus.req_done_o,    0);
        check_eq("rst_err",    bus.req_err_o,     0);
        check_eq("rst_start",  bus.mm_start_o,    0);
        check_eq("rst_en",     bus.req_bram_en_o, 0);
        check_eq("rst_we",     bus.req_bram_we_o, 0);
        check_eq("rst_mmrst",  bus.mm_reset_o,    1);
        @(negedge clock_i);
        reset_i = 1'b1;
        #1;
        check_eq("rel_mmrst_hold", bus.mm_reset_o, 1);
        tick();
        check_eq("rel_mmrst_drop", bus.mm_reset_o, 0);

        // Round-robin: all four held for 8 operations
        core_lat  = 20;
        bus.req_i = 4'b1111;
        last_done = -100;
        for (int op = 0; op < 8; op++) begin
            wait_gnt("rr", 50);
            check_eq("rr_order", bus.gnt_o, 32'(1) << (op % 4));
            if (op > 0) check_eq("rr_gap_ge2", 32'((cyc - last_done) >= 2), 1);
            wait_done("rr", 100);
            check_eq("rr_done", bus.req_done_o, 32'(1) << (op % 4));
            last_done = cyc;
            if (op == 7) bus.req_i = '0;
            tick();
        end
        tick();
        check_eq("rr_idle", bus.gnt_o, 0);

        // Core write routed to port 1 only
        core_wr   = 1'b1;
        bus.req_i = 4'b0010;
        wait_gnt("wr", 50);
        check_eq("wr_gnt", bus.gnt_o, 4'b0010);
        wait_done("wr", 100);
        check_eq("wr_done", bus.req_done_o, 4'b0010);
        bus.req_i = '0;
        core_wr   = 1'b0;
        tick();
        check_eq("wr_ram1", ram[1][5], 17'h1ABCD);
        check_eq("wr_ram0", ram[0][5], 0);
        check_eq("wr_ram2", ram[2][5], 0);
        check_eq("wr_ram3", ram[3][5], 0);
        check_eq("idle_dout", bus.mm_bram_dout_o, 0);

        // Single request on port 2, 300-cycle core
        core_lat  = 300;
        en_seen   = '0;
        bus.req_i = 4'b0100;
        tick();
        check_eq("a_gnt_k1",   bus.gnt_o,      4'b0100);
        check_eq("a_start_k1", bus.mm_start_o, 0);
        tick();
        check_eq("a_start_k2", bus.mm_start_o, 1);
        tick();
        check_eq("a_start_pulse", bus.mm_start_o, 0);
        wait_done("a", 400);
        check_eq("a_done",     bus.req_done_o, 4'b0100);
        check_eq("a_err",      bus.req_err_o,  0);
        check_eq("a_gnt_hold", bus.gnt_o,      4'b0100);
        bus.req_i = '0;
        tick();
        check_eq("a_gnt_clear", bus.gnt_o,      0);
        check_eq("a_done_end",  bus.req_done_o, 0);
        check_eq("a_traffic",   en_seen,        4'b0100);

        // Reset during BUSY; pointer (3 here) must restart at 0
        bus.req_i = 4'b1000;
        wait_gnt("d", 50);
        check_eq("d_gnt", bus.gnt_o, 4'b1000);
        repeat (6) tick();
        bus.req_i = 4'b1010;
        #2;
        reset_i = 1'b0;
        #1;
        check_eq("d_gnt_async",   bus.gnt_o,         0);
        check_eq("d_start_async", bus.mm_start_o,    0);
        check_eq("d_done_async",  bus.req_done_o,    0);
        check_eq("d_en_async",    bus.req_bram_en_o, 0);
        check_eq("d_mmrst_async", bus.mm_reset_o,    1);
        repeat (2) @(posedge clock_i);
        core_lat = 20;
        @(negedge clock_i);
        reset_i = 1'b1;
        #1;
        check_eq("d_mmrst_hold", bus.mm_reset_o, 1);
        tick();
        check_eq("d_mmrst_drop", bus.mm_reset_o, 0);
        check_eq("d_rearb",      bus.gnt_o,      4'b0010);
        wait_done("d", 100);
        check_eq("d_done", bus.req_done_o, 4'b0010);
        bus.req_i = '0;
        tick();

        // Spurious done in IDLE, then request dropped mid-BUSY
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        check_eq("e_spur_gnt",   bus.gnt_o,      0);
        check_eq("e_spur_done",  bus.req_done_o, 0);
        tick();
        check_eq("e_spur_start", bus.mm_start_o, 0);
        core_lat  = 30;
        bus.req_i = 4'b0001;
        wait_gnt("e", 50);
        check_eq("e_gnt", bus.gnt_o, 4'b0001);
        repeat (5) tick();
        bus.req_i = '0;
        wait_done("e", 100);
        check_eq("e_done", bus.req_done_o, 4'b0001);
        check_eq("e_err",  bus.req_err_o,  0);
        tick();

        // Watchdog on the TIMEOUT=64 instance
        wd_bus.req_i = 4'b0001;
        tick();
        check_eq("wd_gnt", wd_bus.gnt_o, 4'b0001);
        tick();
        check_eq("wd_start", wd_bus.mm_start_o, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (wd_bus.mm_reset_o == 1'b0 && n < 200);
        check_eq("wd_busy_cycles", 32'(n - 1), 64);
        check_eq("wd_abort1_done", wd_bus.req_done_o, 0);
        tick();
        check_eq("wd_abort2_mmrst", wd_bus.mm_reset_o, 1);
        check_eq("wd_abort2_done",  wd_bus.req_done_o, 4'b0001);
        check_eq("wd_abort2_err",   wd_bus.req_err_o,  4'b0001);
        wd_bus.req_i = '0;
        tick();
        check_eq("wd_post_mmrst", wd_bus.mm_reset_o, 0);
        check_eq("wd_post_gnt",   wd_bus.gnt_o,      0);
        check_eq("wd_post_done",  wd_bus.req_done_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mm_rr_arbiter.md
# mm_rr_arbiter

Round-robin arbiter and sequencer that shares one Montgomery multiplier core (bridge-BRAM interface, start/done handshake) among `N_REQ` requesters, each owning its own operand/result bridge BRAM. It grants one requester at a time and routes the core's BRAM port to that requester's memory. It issues the core start pulse and waits for core done. It includes a watchdog that resets a hung core. It sits directly above the multiplier top in the accelerator hierarchy.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `s`, 8: operand section count of the shared core; `AW = $clog2(4*s)`.
- `TIMEOUT`, 4096: BUSY cycles allowed before the watchdog fires (≥ 16).
- `clock_i` in 1: single clock.
- `reset_i` in 1: **asynchronous, active-low** reset.
- `req_i` in N_REQ: level request; held until matching `req_done_o`.
- `gnt_o` out N_REQ: one-hot grant, registered.
- `req_done_o` out N_REQ: one-cycle completion pulse per requester.
- `req_err_o` out N_REQ: qualifies `req_done_o`; 1 = watchdog abort.
- `req_bram_en_o` / `req_bram_we_o` out N_REQ each: per-requester BRAM enable/write enable.
- `req_bram_addr_o` out N_REQ*AW: per-requester address bus.
- `req_bram_din_o` out N_REQ*17: per-requester write data.
- `req_bram_dout_i` in N_REQ*17: per-requester read data.
- `mm_start_o` out 1: start pulse to the core.
- `mm_reset_o` out 1: active-high synchronous reset to the core.
- `mm_done_i` in 1: core done pulse.
- `mm_bram_en_i`, `mm_bram_we_i`, `mm_bram_addr_i[AW]`, `mm_bram_din_i[17]` in: core BRAM master signals.
- `mm_bram_dout_o` out 17: read data to the core.

## Operation
- FSM states: IDLE, GRANT, START, BUSY, RELEASE, ABORT.
- IDLE: if any `req_i`, pick the first set bit at or after `rr_ptr` (wrapping) and go to GRANT. Register `gnt_o`.
- GRANT: one settling cycle for the BRAM mux, then go to START.
- START: `mm_start_o`=1 for exactly this cycle, then go to BUSY and clear `wd_cnt`.
- BUSY: `wd_cnt` increments each cycle.
  - `mm_done_i` → RELEASE.
  - `wd_cnt == TIMEOUT-1` → ABORT.
- RELEASE: `req_done_o[g]`=1, `req_err_o[g]`=0. Clear `gnt_o`. Set `rr_ptr = (g+1) mod N_REQ`. Go to IDLE.
- ABORT: `mm_reset_o`=1 for 2 cycles. On the second cycle, `req_done_o[g]`=1 and `req_err_o[g]`=1. Clear `gnt_o`, advance `rr_ptr`, go to IDLE.
- BRAM routing is combinational from the registered grant:
  - Granted port `g` receives the core's en/we/addr/din.
  - All other ports get en=0 and we=0; their addr/din are driven to 0.
  - `mm_bram_dout_o` = `req_bram_dout_i[g]`, or 0 when there is no grant.
- `mm_done_i` outside BUSY is ignored.
- Deassertion of `req_i[g]` while granted is ignored; the operation completes and `req_done_o[g]` still pulses.
- Any `mm_bram_we_i` with no grant is dropped.

## Timing
- Reset values: `gnt_o`=0, `req_done_o`=0, `req_err_o`=0, `mm_start_o`=0, all `req_bram_en_o`/`req_bram_we_o`=0, `rr_ptr`=0, state=IDLE.
- `mm_reset_o`=1 while `reset_i` is low. It drops on the first rising edge after `reset_i` releases.
- Request to grant: `req_i` seen in IDLE at cycle k → `gnt_o` at k+1 → `mm_start_o` at k+2.
- Grant stays stable from k+1 through the RELEASE cycle inclusive. This covers the core's one-cycle registered read path and a final write coincident with done.
- Back-to-back: the next grant is visible no earlier than 2 cycles after RELEASE.
- Simultaneous requests: pointer order decides. A continuously asserted requester waits at most N_REQ−1 operations.
- Reset mid-operation: immediate return to reset values. Pending requests are re-arbitrated from `rr_ptr`=0.

## Structure
- Shared package `mm_pkg`: state enum `arb_state_t`, `BRAM_DW = 17`, and a function `rr_pick(req, ptr)` returning the winning index.
- One sub-module, `mm_bram_mux`: the combinational N_REQ-to-1 BRAM port router.
- FSM and watchdog stay in the top.

## Test plan
- `N_REQ`=4. `req_i`=4'b0100, core model done 300 cycles after start:
  - `gnt_o`=0100 at k+1, `mm_start_o` at k+2.
  - BRAM traffic appears only on port 2.
  - `req_done_o`=0100 with `req_err_o`=0.
- All four requests held for 8 operations → grant order 0,1,2,3,0,1,2,3; every grant gap ≥ 2 cycles.
- Core write to addr 5 data 17'h1ABCD while port 1 is granted → port 1 RAM holds 1ABCD; ports 0, 2, 3 unchanged.
- Core never asserts done, `TIMEOUT`=64:
  - ABORT after 64 BUSY cycles.
  - `mm_reset_o` high for 2 cycles.
  - `req_done_o[g]` and `req_err_o[g]` pulse together.
- `reset_i` low during BUSY:
  - All outputs return to reset values asynchronously.
  - `mm_reset_o`=1 until the first edge after release.
  - A held request is re-served from port 0 priority.
- Spurious `mm_done_i` in IDLE, and `req_i` dropped mid-BUSY → no state change in IDLE; the operation completes normally.
